// File: rtl/iir_inverse_seq.sv
// iir_inverse_seq: first-order recursive inverse of a two-tap pre-emphasis FIR.
//   y[n] = sat16( sat_acc(g*x[n] >>> F) + sat_acc(a*y[n-1] >>> F) )
// One shared 18x16 multiplier is time-multiplexed by a four-state FSM:
//   IDLE -> MUL_X -> MUL_Y -> OUT -> IDLE
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both high. ready_o depends only on the FSM state, and
// valid_o/data_o come straight from registers, so no input reaches an output
// combinationally. Once valid_o is raised it and data_o stay stable until the
// transfer completes. Upstream must hold data_i while valid_i && !ready_o.
module iir_inverse_seq #(
    parameter logic signed [17:0] coef_g         = 18'sd65536,
    parameter logic signed [17:0] coef_a         = 18'sd0,
    parameter int                 inout_width    = 16,
    parameter int                 coef_frac_bits = 16,
    parameter int                 acc_width      = 20
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [inout_width-1:0] data_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    output logic [inout_width-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [1:0]             state_o
);

    localparam int CW = 18;                  // coefficient width
    localparam int PW = CW + inout_width;    // full product width
    localparam int SW = acc_width + 1;       // accumulator sum width

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MUL_X = 2'd1;
    localparam logic [1:0] S_MUL_Y = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    // Saturation bounds, pre-extended to the width they are compared against.
    localparam logic signed [PW-1:0] P_MAX     = {{(PW-acc_width+1){1'b0}}, {(acc_width-1){1'b1}}};
    localparam logic signed [PW-1:0] P_MIN     = {{(PW-acc_width+1){1'b1}}, {(acc_width-1){1'b0}}};
    localparam logic signed [SW-1:0] S_ACC_MAX = {2'b00, {(acc_width-1){1'b1}}};
    localparam logic signed [SW-1:0] S_ACC_MIN = {2'b11, {(acc_width-1){1'b0}}};
    localparam logic signed [SW-1:0] S_OUT_MAX = {{(SW-inout_width+1){1'b0}}, {(inout_width-1){1'b1}}};
    localparam logic signed [SW-1:0] S_OUT_MIN = {{(SW-inout_width+1){1'b1}}, {(inout_width-1){1'b0}}};

    logic        [1:0]             r_state;
    logic signed [inout_width-1:0] r_x;
    logic signed [acc_width-1:0]   r_acc;
    logic signed [inout_width-1:0] r_out;
    logic signed [inout_width-1:0] r_y_prev;

    logic signed [CW-1:0]          w_mul_c;
    logic signed [inout_width-1:0] w_mul_d;
    logic signed [PW-1:0]          w_mul_c_ext;
    logic signed [PW-1:0]          w_mul_d_ext;
    logic signed [PW-1:0]          w_prod;
    logic signed [PW-1:0]          w_shift;
    logic signed [acc_width-1:0]   w_term;
    logic signed [SW-1:0]          w_sum;
    logic signed [acc_width-1:0]   w_sum_acc;
    logic signed [inout_width-1:0] w_sum_out;

    // Operand mux for the shared multiplier: feedback pair in MUL_Y, feed-forward pair otherwise.
    always_comb begin
        w_mul_c = coef_g;
        w_mul_d = r_x;
        if (r_state == S_MUL_Y) begin
            w_mul_c = coef_a;
            w_mul_d = r_y_prev;
        end
    end

    assign w_mul_c_ext = {{inout_width{w_mul_c[CW-1]}}, w_mul_c};
    assign w_mul_d_ext = {{CW{w_mul_d[inout_width-1]}}, w_mul_d};
    assign w_prod      = w_mul_c_ext * w_mul_d_ext;
    // Arithmetic shift floors toward minus infinity; no rounding is applied.
    assign w_shift     = w_prod >>> coef_frac_bits;

    // Saturate the scaled product to the accumulator range.
    always_comb begin
        w_term = w_shift[acc_width-1:0];
        if (w_shift > P_MAX) begin
            w_term = P_MAX[acc_width-1:0];
        end else if (w_shift < P_MIN) begin
            w_term = P_MIN[acc_width-1:0];
        end
    end

    // One guard bit so the sum of two full-range accumulator values cannot wrap.
    assign w_sum = {r_acc[acc_width-1], r_acc} + {w_term[acc_width-1], w_term};

    // Saturate the sum twice: to the accumulator width and to the output sample width.
    always_comb begin
        w_sum_acc = w_sum[acc_width-1:0];
        if (w_sum > S_ACC_MAX) begin
            w_sum_acc = S_ACC_MAX[acc_width-1:0];
        end else if (w_sum < S_ACC_MIN) begin
            w_sum_acc = S_ACC_MIN[acc_width-1:0];
        end
        w_sum_out = w_sum[inout_width-1:0];
        if (w_sum > S_OUT_MAX) begin
            w_sum_out = S_OUT_MAX[inout_width-1:0];
        end else if (w_sum < S_OUT_MIN) begin
            w_sum_out = S_OUT_MIN[inout_width-1:0];
        end
    end

    // FSM and datapath registers; reset wins over any handshake on the same edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_x      <= '0;
            r_acc    <= '0;
            r_out    <= '0;
            r_y_prev <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_x     <= data_i;
                        r_state <= S_MUL_X;
                    end
                end
                S_MUL_X: begin
                    r_acc   <= w_term;
                    r_state <= S_MUL_Y;
                end
                S_MUL_Y: begin
                    // Output is taken from the unsaturated-to-acc sum, not from r_acc.
                    r_acc   <= w_sum_acc;
                    r_out   <= w_sum_out;
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    // Feedback state advances only when the sample is actually delivered.
                    if (ready_i) begin
                        r_y_prev <= r_out;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign valid_o = (r_state == S_OUT);
    assign data_o  = r_out;
    assign state_o = r_state;

endmodule

// File: tb/tb_iir_inverse_seq.sv
// tb_iir_inverse_seq: random and directed stimulus against a behavioural
// model of y[n] = sat16(floor(g*x/2^16) + floor(a*y[n-1]/2^16)).
// Five DUT copies cover the coefficient sets; a selector picks which one is observed.
module tb_iir_inverse_seq;

    localparam int N_CFG = 5;
    // Config index: 0 passthrough, 1 recursion a=0.5, 2 gain ~2, 3 a=1.0, 4 round trip.
    localparam logic [N_CFG*18-1:0] G_PACK = {18'd131071, 18'd65536, 18'd131071, 18'd65536, 18'd65536};
    localparam logic [N_CFG*18-1:0] A_PACK = {18'd32768, 18'd65536, 18'd0, 18'd32768, 18'd0};
    int g_tab [N_CFG] = '{65536, 65536, 131071, 65536, 131071};
    int a_tab [N_CFG] = '{0, 32768, 0, 65536, 32768};

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic [15:0] data_i = '0;

    logic [N_CFG-1:0] ready_v;
    logic [N_CFG-1:0] valid_v;
    logic [15:0]      data_v  [N_CFG];
    logic [1:0]       state_v [N_CFG];

    int          sel = 0;
    logic        cur_ready;
    logic        cur_valid;
    logic [15:0] cur_data;
    logic [1:0]  cur_state;

    // Scoreboard state
    logic [15:0] exp_q[$];
    int          acc_cyc_q[$];
    int          orig_q[$];
    int          model_y = 0;
    bit          rt_mode = 0;
    int          rt_count = 0;
    bit          rand_bp = 0;
    bit          prev_valid = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_out_hs = 0;
    int          last_accept = 0;

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running, required finished");
        $fatal(1, "watchdog expired");
    end

    for (genvar gi = 0; gi < N_CFG; gi++) begin : g_dut
        iir_inverse_seq #(
            .coef_g        (G_PACK[gi*18 +: 18]),
            .coef_a        (A_PACK[gi*18 +: 18]),
            .inout_width   (16),
            .coef_frac_bits(16),
            .acc_width     (20)
        ) u_dut (
            .clk_i  (clk),
            .reset_i(reset_i),
            .data_i (data_i),
            .valid_i(valid_i),
            .ready_o(ready_v[gi]),
            .data_o (data_v[gi]),
            .valid_o(valid_v[gi]),
            .ready_i(ready_i),
            .state_o(state_v[gi])
        );
    end

    always_comb begin
        cur_ready = ready_v[sel];
        cur_valid = valid_v[sel];
        cur_data  = data_v[sel];
        cur_state = state_v[sel];
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model helpers
    function automatic longint floor_div(input longint p, input longint d);
        longint q;
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_step(input int x);
        longint s;
        s = floor_div(longint'(g_tab[sel]) * x, 65536) + floor_div(longint'(a_tab[sel]) * model_y, 65536);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        model_y = int'(s);
        return int'(s);
    endfunction

    // Driver tasks: all start and end at posedge + 1.
    task automatic do_reset(input int cfg);
        @(posedge clk); #1;
        sel = cfg;
        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        orig_q.delete();
        model_y = 0;
        repeat (2) @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("rst_ready", cur_ready, 1);
        check("rst_valid", cur_valid, 0);
        check("rst_data", $signed(cur_data), 0);
        @(posedge clk); #1;
    endtask

    task automatic send(input int x);
        int waited;
        valid_i = 1'b1;
        data_i  = 16'(x);
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!cur_ready && waited < 60);
        if (!cur_ready) begin
            check("accept_timeout", 0, 1);
            @(posedge clk); #1;
            valid_i = 1'b0;
            return;
        end
        exp_q.push_back(16'(model_step(x)));
        acc_cyc_q.push_back(cyc);
        last_accept = cyc;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: latency on valid rise, data on each output handshake.
    initial begin
        logic [15:0] e;
        int          xo;
        int          d;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                prev_valid = 0;
            end else begin
                if (cur_valid && !prev_valid && acc_cyc_q.size() > 0)
                    check("latency", cyc - acc_cyc_q[0], 3);
                if (cur_valid && ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", $signed(cur_data), 99999);
                    end else begin
                        e = exp_q.pop_front();
                        void'(acc_cyc_q.pop_front());
                        check("data_o", $signed(cur_data), $signed(e));
                        if (rt_mode && orig_q.size() > 0) begin
                            xo = orig_q.pop_front();
                            d  = $signed(cur_data) - xo;
                            if (rt_count > 0)
                                check("round_trip_err", (d <= 2 && d >= -2) ? 0 : d, 0);
                            rt_count++;
                        end
                    end
                    last_out_hs = cyc;
                end
                prev_valid = cur_valid;
            end
        end
    end

    initial begin
        int x;
        int xp;
        int e;
        int w;

        // Passthrough
        do_reset(0);
        send(1000); send(-1000); send(32767); send(-32768);
        drain();

        // Recursion step response, then floor behaviour on negative feedback
        do_reset(1);
        repeat (4) send(1000);
        drain();
        do_reset(1);
        send(-1001); send(0); send(0);
        drain();

        // Saturation of the feed-forward path and of the recursion
        do_reset(2);
        send(30000); send(-30000);
        drain();
        do_reset(3);
        repeat (3) send(20000);
        drain();

        // Backpressure with the next sample already offered
        do_reset(1);
        ready_i = 1'b0;
        send(1200);
        fork
            send(-700);
            begin
                w = 0;
                while (!cur_valid && w < 20) begin
                    @(negedge clk);
                    w++;
                end
                check("bp_valid_seen", cur_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clk);
                    check("bp_valid", cur_valid, 1);
                    check("bp_ready", cur_ready, 0);
                    if (exp_q.size() > 0) check("bp_data", $signed(cur_data), $signed(exp_q[0]));
                end
                @(posedge clk); #1;
                ready_i = 1'b1;
            end
        join
        check("accept_after_hs", last_accept - last_out_hs, 1);
        drain();

        // Reset in MUL_Y must also clear the feedback register
        do_reset(1);
        send(4000);
        drain();
        send(2000);
        @(negedge clk);
        @(negedge clk);
        check("mid_state_muly", cur_state, 2);
        reset_i = 1'b1;
        exp_q.delete();
        acc_cyc_q.delete();
        model_y = 0;
        @(posedge clk); #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", cur_valid, 0);
        check("mid_rst_ready", cur_ready, 1);
        @(posedge clk); #1;
        send(1000);
        drain();

        // Random samples with random downstream stalls
        do_reset(1);
        rand_bp = 1;
        fork
            begin
                for (int i = 0; i < 20; i++) send(int'($urandom_range(0, 65535)) - 32768);
                rand_bp = 0;
            end
            begin
                while (rand_bp) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        drain();

        // Round trip through the upstream FIR (b0 = 0.5, b1 = -0.25 in Q1.17).
        // Inputs are multiples of 4 so the FIR output is exact; the remaining
        // error comes only from the inverse's floor steps and stays within 2 LSB.
        do_reset(4);
        rt_mode  = 1;
        rt_count = 0;
        xp = 0;
        for (int i = 0; i < 30; i++) begin
            x = 4 * int'($urandom_range(0, 4000)) - 8000;
            e = int'(floor_div(65536 * longint'(x) - 32768 * longint'(xp), 131072));
            xp = x;
            orig_q.push_back(x);
            send(e);
        end
        drain();
        rt_mode = 0;

        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_inverse_seq.md
# iir_inverse_seq

First-order recursive inverse filter that undoes the two-tap pre-emphasis FIR applied upstream in the audio path. It computes y[n] = g·x[n] + a·y[n−1], with g = 1/b0 and a = −b1/b0 supplied as parameters. A single shared 18×16 multiplier is time-multiplexed by a small FSM. Samples move over valid/ready handshakes on both sides, and every intermediate result saturates.

## Interface
- coef_g, 18'sd65536: feed-forward gain g, signed Q2.16 (range [−2, 2)).
- coef_a, 18'sd0: feedback coefficient a, signed Q2.16.
- inout_width, 16: sample width, signed Q1.15.
- coef_frac_bits, 16: fractional bits of the coefficients.
- acc_width, 20: signed accumulator width.
- clk_i, input, 1: single clock; every register updates on its rising edge.
- reset_i, input, 1: synchronous, active-high reset.
- data_i, input, 16: input sample x[n], signed Q1.15.
- valid_i, input, 1: data_i is valid.
- ready_o, output, 1: block accepts a sample this cycle.
- data_o, output, 16: output sample y[n], signed Q1.15.
- valid_o, output, 1: data_o is valid.
- ready_i, input, 1: downstream accepts data_o this cycle.

## Operation
- FSM states: IDLE, MUL_X, MUL_Y, OUT.
- IDLE
  - ready_o = 1.
  - On valid_i && ready_o, latch x_reg ← data_i and go to MUL_X.
- MUL_X
  - Compute p = coef_g·x_reg as a full 34-bit signed product.
  - Arithmetic-shift p right by coef_frac_bits (truncates toward −∞).
  - Saturate to acc_width, store in acc, go to MUL_Y.
- MUL_Y
  - Compute p = coef_a·y_prev and shift it the same way.
  - acc ← sat_acc(acc + shifted p), using an (acc_width+1)-bit sum.
  - out_reg ← acc + shifted p saturated to [−32768, 32767]. This value is computed from the same sum, not from the registered acc.
  - Go to OUT.
- OUT
  - valid_o = 1 and data_o = out_reg.
  - On ready_i: y_prev ← out_reg and go to IDLE.
  - Otherwise hold data_o and valid_o stable.
- y_prev holds the saturated 16-bit output. It updates only on a completed output handshake.
- Single multiplier: the operand mux selects (coef_g, x_reg) in MUL_X and (coef_a, y_prev) in MUL_Y.
- ready_o is 1 only in IDLE. A sample offered in any other state is not consumed and must be held by upstream.
- Reset at any time: the FSM goes to IDLE and x_reg, acc, out_reg and y_prev clear to 0. Any in-flight sample is discarded.

## Timing
- Reset values: ready_o = 1 (IDLE), valid_o = 0, data_o = 0.
- Input accepted at edge k → MUL_X during cycle k+1, MUL_Y during k+2, valid_o high from cycle k+3.
- Latency: 3 cycles from input handshake to valid_o.
- Maximum throughput: one sample per 4 cycles, reached with ready_i held high.
- Output handshake completes at the first edge with valid_o && ready_i. ready_o rises in the following cycle.
- Backpressure: data_o and valid_o stay stable while ready_i = 0, and ready_o stays 0 throughout.
- Reset asserted during any state takes priority over every handshake on that edge.
- No combinational path from valid_i or ready_i to any output.

## Test plan
1. **Passthrough**
   - Stimulus: coef_g = 65536, coef_a = 0; inputs 1000, −1000, 32767, −32768.
   - Required: identical outputs, each with valid_o exactly 3 cycles after acceptance.
2. **Recursion**
   - Stimulus: coef_g = 65536, coef_a = 32768; input step of 1000 for four samples.
   - Required: outputs 1000, 1500, 1750, 1875.
   - Follow-up stimulus: after reset, inputs 0 then 0 with y_prev = −1001 preloaded via one prior sample x = −1001.
   - Required: −501 (floor truncation).
3. **Saturation**
   - Stimulus: coef_g = 131071, coef_a = 0. Required: x = 30000 → 32767; x = −30000 → −32768.
   - Stimulus: coef_a = 65536, constant x = 20000. Required: outputs 20000, 32767, 32767 with no wrap.
4. **Backpressure**
   - Stimulus: ready_i held low 5 cycles while in OUT; valid_i held high with the next sample.
   - Required: data_o stable, ready_o = 0 throughout, the next sample accepted the cycle after the output handshake, and no sample lost or duplicated.
5. **Reset mid-operation**
   - Stimulus: assert reset_i during MUL_Y, then feed x = 1000 with coef_a = 32768.
   - Required: valid_o = 0 the cycle after reset and the first output is 1000, confirming y_prev was cleared.
6. **Round trip**
   - Stimulus: drive the upstream FIR configured b0 = 65536, b1 = −32768 (Q1.17, i.e. 0.5 and −0.25) into this block with coef_g = 131071 and coef_a = 32768, using a random input sequence bounded to ±8000.
   - Required: recovered output within ±2 LSB of the original input after the first sample.
